// File: rtl/tinycpu_pkg.sv
// Shared encodings and default widths for the tinycpu run controller slice.
package tinycpu_pkg;

  localparam int PC_W  = 12;
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    CS_IDLE   = 3'd0,
    CS_FETCHA = 3'd1,
    CS_FETCHB = 3'd2,
    CS_EXECA  = 3'd3,
    CS_EXECB  = 3'd4
  } cs_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP       = 3'd2,
    ST_PAUSE_USER = 3'd3,
    ST_PAUSE_BP   = 3'd4,
    ST_HALTED     = 3'd5
  } run_state_e;

  function automatic logic is_busy(input run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/tinycpu_runctl_if.sv
// Host-command, core-observation and status bundle of the tinycpu run controller.
interface tinycpu_runctl_if #(
  parameter int PC_W  = tinycpu_pkg::PC_W,
  parameter int CNT_W = tinycpu_pkg::CNT_W
);
  logic             start;
  logic             stop;
  logic             step;
  logic             clr_cnt;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [2:0]       cs;
  logic [PC_W-1:0]  pcout;
  logic             cpu_run;
  logic             cpu_ce;
  logic [2:0]       status;
  logic             busy;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, stop, step, clr_cnt, bp_en, bp_addr, cs, pcout,
    input  cpu_run, cpu_ce, status, busy, cycle_cnt, instr_cnt
  );

  modport slave (
    input  start, stop, step, clr_cnt, bp_en, bp_addr, cs, pcout,
    output cpu_run, cpu_ce, status, busy, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/tinycpu_satcnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module tinycpu_satcnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tinycpu_runctl.sv
// Run/step/breakpoint sequencer gating the tinycpu clock enable.
//   state         | meaning
//   ST_IDLE       | out of reset, core held (run=0)
//   ST_RUN        | free-running, ce=1 until stop/bp/HALT
//   ST_STEP       | running for exactly one instruction
//   ST_PAUSE_USER | parked at a boundary after stop or step
//   ST_PAUSE_BP   | parked on the breakpoint fetch
//   ST_HALTED     | core executed HALT and returned to cs=IDLE
module tinycpu_runctl
  import tinycpu_pkg::*;
#(
  parameter int CNT_W = tinycpu_pkg::CNT_W,
  parameter int PC_W  = tinycpu_pkg::PC_W
) (
  input logic             clk,
  input logic             reset,
  tinycpu_runctl_if.slave bus
);

  run_state_e       state, state_nx;
  logic             stop_pend, stop_pend_nx;
  logic             skip_bp, skip_bp_nx;
  logic             ran, ran_nx;
  logic             busy_q;
  logic             cmd_start, cmd_step;
  logic             boundary, bp_hit, ce, retire, halt_seen;
  logic [PC_W-1:0]  pc_cur, bp_cur;
  logic [CNT_W-1:0] cycle_q, instr_q;

  assign pc_cur    = bus.pcout;
  assign bp_cur    = bus.bp_addr;
  assign cmd_step  = bus.step & ~bus.stop;
  assign cmd_start = bus.start & ~bus.stop & ~bus.step;
  assign boundary  = (bus.cs == CS_FETCHA);
  assign bp_hit    = bus.bp_en & boundary & (pc_cur == bp_cur) & ~skip_bp;
  // Combinational so the core is frozen in the very cycle the breakpoint fetch appears.
  assign ce        = is_busy(state) & ~bp_hit;
  assign retire    = ce & (bus.cs == CS_EXECB);
  assign halt_seen = (bus.cs == CS_IDLE) & ran;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      stop_pend <= 1'b0;
      skip_bp   <= 1'b0;
      ran       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      stop_pend <= stop_pend_nx;
      skip_bp   <= skip_bp_nx;
      ran       <= ran_nx;
      busy_q    <= is_busy(state_nx);
    end
  end

  always_comb begin
    state_nx     = state;
    stop_pend_nx = stop_pend;
    skip_bp_nx   = skip_bp;
    ran_nx       = ran;

    if (ce && (bus.cs != CS_IDLE))   ran_nx     = 1'b1;
    if (ce && (bus.cs != CS_FETCHA)) skip_bp_nx = 1'b0;

    unique case (state)
      ST_IDLE, ST_HALTED: begin
        if (cmd_step) begin
          state_nx   = ST_STEP;
          skip_bp_nx = 1'b1;
          ran_nx     = 1'b0;
        end else if (cmd_start) begin
          state_nx   = ST_RUN;
          skip_bp_nx = 1'b1;
          ran_nx     = 1'b0;
        end
      end
      ST_PAUSE_USER, ST_PAUSE_BP: begin
        if (cmd_step) begin
          state_nx   = ST_STEP;
          skip_bp_nx = 1'b1;
        end else if (cmd_start) begin
          state_nx   = ST_RUN;
          skip_bp_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.stop) stop_pend_nx = 1'b1;
        if (bp_hit) begin
          state_nx = ST_PAUSE_BP;
        end else if (halt_seen) begin
          state_nx     = ST_HALTED;
          stop_pend_nx = 1'b0;
        end else if (retire && stop_pend) begin
          state_nx     = ST_PAUSE_USER;
          stop_pend_nx = 1'b0;
        end
      end
      ST_STEP: begin
        if (bp_hit) begin
          state_nx = ST_PAUSE_BP;
        end else if (halt_seen) begin
          state_nx     = ST_HALTED;
          stop_pend_nx = 1'b0;
        end else if (retire) begin
          state_nx = ST_PAUSE_USER;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  tinycpu_satcnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ce),
    .clr   (bus.clr_cnt),
    .cnt   (cycle_q)
  );

  tinycpu_satcnt #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .clr   (bus.clr_cnt),
    .cnt   (instr_q)
  );

  assign bus.cpu_ce    = ce;
  assign bus.cpu_run   = (state == ST_RUN) || (state == ST_STEP) ||
                         (state == ST_PAUSE_USER) || (state == ST_PAUSE_BP);
  assign bus.status    = state;
  assign bus.busy      = busy_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;

endmodule

// File: tb/tb_tinycpu_runctl.sv
// Bench for tinycpu_runctl: small tinycpu cs/pc model plus a status-transition scoreboard.
module tb_tinycpu_runctl;
  import tinycpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tinycpu_runctl_if #(.PC_W(12), .CNT_W(32)) bus();
  tinycpu_runctl_if #(.PC_W(12), .CNT_W(4))  sbus();

  tinycpu_runctl #(.CNT_W(32), .PC_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  tinycpu_runctl #(.CNT_W(4), .PC_W(12)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  assign sbus.start   = bus.start;
  assign sbus.stop    = bus.stop;
  assign sbus.step    = bus.step;
  assign sbus.clr_cnt = bus.clr_cnt;
  assign sbus.bp_en   = bus.bp_en;
  assign sbus.bp_addr = bus.bp_addr;
  assign sbus.cs      = bus.cs;
  assign sbus.pcout   = bus.pcout;

  // Core model: advances only on cpu_ce; HALT is the instruction at halt_pc.
  logic [2:0]  core_cs     = 3'd0;
  logic [11:0] core_pc     = 12'd0;
  logic        core_halted = 1'b0;
  logic        core_ld     = 1'b0;
  logic [11:0] core_ld_pc  = 12'd0;
  logic [11:0] halt_pc     = 12'd100;

  assign bus.cs    = core_cs;
  assign bus.pcout = core_pc;

  always @(posedge clk) begin
    if (core_ld) begin
      core_pc     <= core_ld_pc;
      core_cs     <= CS_IDLE;
      core_halted <= 1'b0;
    end else if (bus.cpu_ce) begin
      case (core_cs)
        CS_IDLE:   if (bus.cpu_run && !core_halted) core_cs <= CS_FETCHA;
        CS_FETCHA: core_cs <= CS_FETCHB;
        CS_FETCHB: core_cs <= CS_EXECA;
        CS_EXECA:  core_cs <= CS_EXECB;
        CS_EXECB: begin
          if (core_pc == halt_pc) begin
            core_cs     <= CS_IDLE;
            core_halted <= 1'b1;
          end else begin
            core_pc <= core_pc + 12'd1;
            core_cs <= CS_FETCHA;
          end
        end
        default: core_cs <= CS_IDLE;
      endcase
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: expected status values are queued with each command and
  // popped whenever the DUT status register changes.
  logic [2:0] exp_q[$];
  logic [2:0] prev_status = 3'd0;

  always @(negedge clk) begin
    if (bus.status !== prev_status) begin
      if (exp_q.size() == 0)
        check_val("status_unexpected", 32'(bus.status), 32'hFF);
      else
        check_val("status_seq", 32'(bus.status), 32'(exp_q.pop_front()));
      prev_status <= bus.status;
    end
  end

  task automatic pulse_cmd(input logic s_start, input logic s_stop, input logic s_step, input logic s_clr);
    bus.start   = s_start;
    bus.stop    = s_stop;
    bus.step    = s_step;
    bus.clr_cnt = s_clr;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.step    = 1'b0;
    bus.clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_core(input logic [11:0] pc);
    core_ld_pc = pc;
    core_ld    = 1'b1;
    @(negedge clk);
    core_ld    = 1'b0;
  endtask

  task automatic wait_status(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && bus.status !== s; i++) @(negedge clk);
    check_val(tag, 32'(bus.status), 32'(s));
  endtask

  task automatic wait_cs_pc(input logic [2:0] c, input logic [11:0] pc, input int budget, input string tag);
    for (int i = 0; i < budget && {bus.cs, bus.pcout} !== {c, pc}; i++) @(negedge clk);
    check_val(tag, 32'({bus.cs, bus.pcout}), 32'({c, pc}));
  endtask

  task automatic wait_instr(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && bus.instr_cnt !== 32'(n); i++) @(negedge clk);
    check_val(tag, bus.instr_cnt, 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.step    = 1'b0;
    bus.clr_cnt = 1'b0;
    bus.bp_en   = 1'b0;
    bus.bp_addr = 12'd0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_status", 32'(bus.status), 32'd0);
    check_val("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_val("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    load_core(12'd0);

    // Asynchronous reset in the middle of a free run
    exp_q.push_back(ST_RUN);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("run_busy", 32'(bus.busy), 32'd1);
    repeat (37) @(posedge clk);
    exp_q.push_back(ST_IDLE);
    #2 reset = 1'b0;
    #1;
    check_val("midrst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_val("midrst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check_val("midrst_status", 32'(bus.status), 32'd0);
    check_val("midrst_cycle", bus.cycle_cnt, 32'd0);
    check_val("midrst_instr", bus.instr_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Three-instruction program ending in HALT
    halt_pc = 12'd2;
    load_core(12'd0);
    exp_q.push_back(ST_RUN);
    exp_q.push_back(ST_HALTED);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_status(ST_HALTED, 60, "halt_wait");
    check_val("halt_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_val("halt_busy", 32'(bus.busy), 32'd0);
    check_val("halt_instr", bus.instr_cnt, 32'd3);
    check_val("halt_cycle", bus.cycle_cnt, 32'd14);

    // Single step from IDLE
    exp_q.push_back(ST_IDLE);
    do_reset();
    halt_pc = 12'd100;
    load_core(12'd0);
    exp_q.push_back(ST_STEP);
    exp_q.push_back(ST_PAUSE_USER);
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("step_busy", 32'(bus.busy), 32'd1);
    wait_status(ST_PAUSE_USER, 30, "step_wait");
    check_val("step_instr", bus.instr_cnt, 32'd1);
    check_val("step_cycle", bus.cycle_cnt, 32'd5);
    check_val("step_pc", 32'(bus.pcout), 32'd1);
    check_val("step_ce", 32'(bus.cpu_ce), 32'd0);

    // Breakpoint at 0x004, then resume past it
    exp_q.push_back(ST_IDLE);
    do_reset();
    load_core(12'd0);
    bus.bp_en   = 1'b1;
    bus.bp_addr = 12'h004;
    exp_q.push_back(ST_RUN);
    exp_q.push_back(ST_PAUSE_BP);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cs_pc(CS_FETCHA, 12'h004, 60, "bp_fetch_wait");
    check_val("bp_ce_same_cycle", 32'(bus.cpu_ce), 32'd0);
    check_val("bp_status_lag", 32'(bus.status), 32'(ST_RUN));
    wait_status(ST_PAUSE_BP, 5, "bp_wait");
    check_val("bp_instr", bus.instr_cnt, 32'd4);
    check_val("bp_cycle", bus.cycle_cnt, 32'd17);
    check_val("bp_cpu_run", 32'(bus.cpu_run), 32'd1);
    check_val("bp_pc_held", 32'(bus.pcout), 32'h004);
    exp_q.push_back(ST_RUN);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cs_pc(CS_FETCHB, 12'h005, 20, "resume_wait");
    check_val("resume_instr", bus.instr_cnt, 32'd5);
    check_val("resume_status", 32'(bus.status), 32'(ST_RUN));

    // Stop during FETCHB: instruction still retires, then pause
    exp_q.push_back(ST_PAUSE_USER);
    pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    wait_cs_pc(CS_EXECB, 12'h005, 10, "stop_execb_wait");
    check_val("stop_ce_execb", 32'(bus.cpu_ce), 32'd1);
    wait_status(ST_PAUSE_USER, 10, "stop_wait");
    check_val("stop_instr", bus.instr_cnt, 32'd6);
    check_val("stop_pc", 32'(bus.pcout), 32'h006);
    check_val("stop_ce", 32'(bus.cpu_ce), 32'd0);

    // stop+start together while paused: stop wins, start is dropped
    pulse_cmd(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("stopstart_status", 32'(bus.status), 32'(ST_PAUSE_USER));
    check_val("stopstart_ce", 32'(bus.cpu_ce), 32'd0);
    check_val("stopstart_cycle", bus.cycle_cnt, 32'd25);

    // clr_cnt coincident with a retire, then saturation on the narrow build
    exp_q.push_back(ST_RUN);
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cs_pc(CS_EXECB, 12'h006, 10, "clr_execb_wait");
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("clr_instr", bus.instr_cnt, 32'd0);
    check_val("clr_cycle", bus.cycle_cnt, 32'd0);
    check_val("clr_small_instr", 32'(sbus.instr_cnt), 32'd0);
    wait_instr(15, 100, "sat_wait15");
    check_val("sat_small_instr15", 32'(sbus.instr_cnt), 32'hF);
    check_val("sat_small_cycle", 32'(sbus.cycle_cnt), 32'hF);
    wait_instr(16, 10, "sat_wait16");
    check_val("sat_small_instr_hold", 32'(sbus.instr_cnt), 32'hF);
    check_val("sat_main_cycle", bus.cycle_cnt, 32'd64);
    exp_q.push_back(ST_PAUSE_USER);
    pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    wait_status(ST_PAUSE_USER, 20, "final_stop_wait");
    check_val("final_busy", 32'(bus.busy), 32'd0);

    @(negedge clk);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tinycpu_runctl.md
Name: tinycpu_runctl

Overview:
- Run/step/breakpoint sequencer for the tinycpu core.
- Drives the core's run input and a clock-enable (cpu_ce) consumed by the tinycpu clock-enable wrapper.
- Watches the core's cs and pcout outputs to detect instruction boundaries, breakpoints and HALT.
- Keeps cycle and retired-instruction counters for the host/debug side.

Parameters:
CNT_W, 32, width of cycle_cnt and instr_cnt
PC_W, 12, width of pcout/bp_addr (matches the tinycpu address bus)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  pulse: begin/resume free-running execution
stop  input  1  pulse: pause at the next instruction boundary
step  input  1  pulse: execute exactly one instruction
clr_cnt  input  1  pulse: clear both counters
bp_en  input  1  breakpoint enable
bp_addr  input  PC_W  breakpoint fetch address
cs  input  3  tinycpu state (IDLE=0, FETCHA=1, FETCHB=2, EXECA=3, EXECB=4)
pcout  input  PC_W  tinycpu program counter
cpu_run  output  1  to tinycpu run
cpu_ce  output  1  tinycpu clock enable (combinational)
status  output  3  0 IDLE, 1 RUN, 2 STEP, 3 PAUSE_USER, 4 PAUSE_BP, 5 HALTED
busy  output  1  status is RUN or STEP
cycle_cnt  output  CNT_W  cycles with cpu_ce=1
instr_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset (asynchronous, active-low, usable mid-operation): state IDLE, cpu_run=0, cpu_ce=0, busy=0, status=0, both counters 0, stop_pend=0, skip_bp=0, ran=0.
- Events:
  - retire = cpu_ce && cs==EXECB.
  - boundary = cs==FETCHA.
  - bp_hit = bp_en && boundary && pcout==bp_addr && !skip_bp.
- cpu_ce = (state RUN or STEP) && !bp_hit. It is combinational, with zero latency, so the core never advances past a breakpoint fetch.
- cpu_run = 1 in RUN, STEP, PAUSE_USER and PAUSE_BP; 0 in IDLE and HALTED.
- Command priority when pulses coincide: stop > step > start. Commands that are illegal in the current state are ignored.
- IDLE/HALTED: start -> RUN; step -> STEP. Each sets skip_bp=1 and ran=0.
- PAUSE_USER/PAUSE_BP: start -> RUN; step -> STEP. Each sets skip_bp=1.
- RUN:
  - stop sets stop_pend.
  - On retire with stop_pend -> PAUSE_USER; stop_pend cleared.
  - bp_hit -> PAUSE_BP in the same cycle.
  - cs==IDLE && ran -> HALTED (HALT executed).
- STEP:
  - retire -> PAUSE_USER.
  - cs==IDLE && ran -> HALTED.
  - bp_hit -> PAUSE_BP.
  - stop in STEP is a no-op; the step completes.
- ran: set on any cycle where cpu_ce && cs!=IDLE.
- skip_bp: cleared on the first cpu_ce cycle with cs!=FETCHA. This lets resume from a breakpoint fetch the matching instruction once.
- HALTED also clears stop_pend.
- Counters:
  - cycle_cnt +1 per cpu_ce cycle; instr_cnt +1 per retire.
  - Both saturate at all-ones; no wrap.
  - clr_cnt is synchronous and wins over a same-cycle increment.
- status and busy are registered from state. They reflect a transition one cycle after the triggering event. cpu_ce reacts to bp_hit immediately.

Decomposition:
- Shared package tinycpu_pkg:
  - cs encodings CS_IDLE..CS_EXECB
  - runctl state/status encodings ST_IDLE..ST_HALTED
  - default widths PC_W, CNT_W
- One sub-module, tinycpu_satcnt: CNT_W saturating counter with inc and sync clr. Instantiated twice.
- The FSM stays in tinycpu_runctl.

Test Plan:
- Reset low mid-RUN at cycle 37 -> cpu_run=0, cpu_ce=0, status=0, both counters 0 immediately (asynchronous).
- Start with a 3-instruction program ending in HALT, bp_en=0 -> status 1 until cs returns to 0, then status=5, cpu_run=0, instr_cnt=3.
- step pulse from IDLE -> cpu_ce high through one FETCHA..EXECB sequence; instr_cnt=1; status=3; pcout advanced by 1.
- bp_en=1, bp_addr=0x004, start -> cpu_ce=0 in the cycle cs=1 and pcout=0x004; status=4; instr_cnt=4. A second start fetches 0x004 without re-triggering the breakpoint.
- stop asserted during cs=FETCHB while running -> cpu_ce stays 1 through EXECB retire, then status=3. stop+start in the same cycle -> stop wins.
- clr_cnt with a same-cycle retire -> instr_cnt=0. Preload the counter to all-ones (CNT_W=4 build), one more retire -> stays 4'hF.
